// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between the datapath (master) and
//               the byte-lane data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  byteEnable;
    logic        busy;
    logic        ready;
    logic [31:0] rd;
    logic        err;

    modport master (
        output req, we, a, wd, byteEnable,
        input  busy, ready, rd, err
    );

    modport slave (
        input  req, we, a, wd, byteEnable,
        output busy, ready, rd, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-organised data RAM with byte-lane enables, a
//               programmable number of wait states and a one-cycle ready
//               pulse. One request in flight at a time; requests arriving
//               while busy are dropped. Optional access-fault reporting is
//               compiled in with the DMEM_RESP_ERR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_responder_if.slave bus
);

    localparam int         c_AW        = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_WAIT = 2'd1,
        c_RESP = 2'd2
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [3:0]  r_cnt_q,   w_cnt_d;
    logic        r_we_q,    w_we_d;
    logic [31:0] r_a_q,     w_a_d;
    logic [31:0] r_wd_q,    w_wd_d;
    logic [3:0]  r_be_q,    w_be_d;
    logic [31:0] r_rd_q,    w_rd_d;
    logic        r_err_q,   w_err_d;

    logic             w_access;
    logic             w_acc_we;
    logic [31:0]      w_acc_a;
    logic [31:0]      w_acc_wd;
    logic [3:0]       w_acc_be;
    logic             w_fault;
    logic             w_mem_we;
    logic [c_AW-1:0]  w_idx;
    logic [31:0]      w_ram_word;
    logic [31:0]      w_rd_word;

    // Access operands: live inputs on a zero-wait accept edge, latched copy otherwise
    always_comb begin
        w_acc_we = r_we_q;
        w_acc_a  = r_a_q;
        w_acc_wd = r_wd_q;
        w_acc_be = r_be_q;
        if (r_state_q == c_IDLE) begin
            w_acc_we = bus.we;
            w_acc_a  = bus.a;
            w_acc_wd = bus.wd;
            w_acc_be = bus.byteEnable;
        end
    end

    assign w_idx = w_acc_a[c_AW+1:2];

`ifdef DMEM_RESP_ERR_EN
    // Misaligned or out-of-range addresses fault instead of touching the RAM
    assign w_fault = (|w_acc_a[1:0]) || (|w_acc_a[31:c_AW+2]);
`else
    // Offset and upper address bits are don't-care: the address wraps
    assign w_fault = 1'b0;
    wire w_unused_addr = &{1'b0, w_acc_a[1:0], w_acc_a[31:c_AW+2]};
`endif

    assign w_mem_we = w_access && w_acc_we && !w_fault;

    // One byte-wide RAM per lane so each lane enable maps to its own write port
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            // Lane write on the access edge when this lane is enabled
            always_ff @(posedge clk) begin
                if (w_mem_we && w_acc_be[i]) begin
                    r_mem[w_idx] <= w_acc_wd[8*i +: 8];
                end
            end

            assign w_ram_word[8*i +: 8] = r_mem[w_idx];
        end
    endgenerate

    // Disabled read lanes return zero
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            w_rd_word[8*i +: 8] = w_acc_be[i] ? w_ram_word[8*i +: 8] : 8'h00;
        end
    end

    // Next-state, wait counter, request capture and response data
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_we_d    = r_we_q;
        w_a_d     = r_a_q;
        w_wd_d    = r_wd_q;
        w_be_d    = r_be_q;
        w_rd_d    = r_rd_q;
        w_err_d   = r_err_q;
        w_access  = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (bus.req) begin
                    w_we_d = bus.we;
                    w_a_d  = bus.a;
                    w_wd_d = bus.wd;
                    w_be_d = bus.byteEnable;
                    if (WAIT_STATES == 0) begin
                        w_access  = 1'b1;
                        w_state_d = c_RESP;
                    end else begin
                        w_cnt_d   = c_WAIT_LOAD;
                        w_state_d = c_WAIT;
                    end
                end
            end
            c_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_access  = 1'b1;
                    w_state_d = c_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            c_RESP: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        if (w_access) begin
            w_err_d = w_fault;
            w_rd_d  = (w_fault || w_acc_we) ? 32'h0 : w_rd_word;
        end
    end

    // State and request registers; reset clears outputs without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= c_IDLE;
            r_cnt_q   <= 4'd0;
            r_we_q    <= 1'b0;
            r_a_q     <= 32'h0;
            r_wd_q    <= 32'h0;
            r_be_q    <= 4'h0;
            r_rd_q    <= 32'h0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_we_q    <= w_we_d;
            r_a_q     <= w_a_d;
            r_wd_q    <= w_wd_d;
            r_be_q    <= w_be_d;
            r_rd_q    <= w_rd_d;
            r_err_q   <= w_err_d;
        end
    end

    assign bus.busy  = (r_state_q != c_IDLE);
    assign bus.ready = (r_state_q == c_RESP);
    assign bus.rd    = r_rd_q;
    assign bus.err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Three responders (0, 1 and 3 wait states) share one stimulus
//               stream; each is scored against its own queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [3:0]  be = 4'h0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.req = req; assign bus0.we = we; assign bus0.a = a; assign bus0.wd = wd; assign bus0.byteEnable = be;
    assign bus1.req = req; assign bus1.we = we; assign bus1.a = a; assign bus1.wd = wd; assign bus1.byteEnable = be;
    assign bus2.req = req; assign bus2.we = we; assign bus2.a = a; assign bus2.wd = wd; assign bus2.byteEnable = be;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic        busy_s [3];
    logic        rdy_s  [3];
    logic        err_s  [3];
    logic [31:0] rd_s   [3];

    assign busy_s[0] = bus0.busy; assign rdy_s[0] = bus0.ready; assign err_s[0] = bus0.err; assign rd_s[0] = bus0.rd;
    assign busy_s[1] = bus1.busy; assign rdy_s[1] = bus1.ready; assign err_s[1] = bus1.err; assign rd_s[1] = bus1.rd;
    assign busy_s[2] = bus2.busy; assign rdy_s[2] = bus2.ready; assign err_s[2] = bus2.err; assign rd_s[2] = bus2.rd;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int          at_edge;
        logic [31:0] rd;
        logic        err;
    } resp_t;

    // Reference model state, one set per responder
    resp_t       exp_q   [3][$];
    logic [31:0] mdl_mem [3][DEPTH];
    int          last_acc  [3];
    logic        pend_v    [3];
    int          pend_edge [3];
    logic        p_we [3];
    logic [31:0] p_a  [3];
    logic [31:0] p_wd [3];
    logic [3:0]  p_be [3];
    logic [31:0] hold_rd  [3];
    logic        hold_err [3];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @cyc %0d: got %h, want %h", name, d, cyc, act, exp);
        end
    endtask

    // Perform the access of the pending request of responder d on edge cyc
    task automatic model_access(input int d);
        logic        f;
        int          idx;
        logic [31:0] w;
        resp_t       r;
        f = 1'b0;
`ifdef DMEM_RESP_ERR_EN
        f = (p_a[d] % 4 != 0) || (p_a[d] >= 32'(4 * DEPTH));
`endif
        idx       = int'((p_a[d] / 4) % DEPTH);
        r.at_edge = cyc;
        r.err     = f;
        r.rd      = 32'h0;
        if (!f) begin
            w = mdl_mem[d][idx];
            for (int i = 0; i < 4; i++) begin
                if (p_be[d][i]) begin
                    if (p_we[d]) w[8*i +: 8] = p_wd[d][8*i +: 8];
                    else         r.rd[8*i +: 8] = w[8*i +: 8];
                end
            end
            if (p_we[d]) mdl_mem[d][idx] = w;
        end
        exp_q[d].push_back(r);
    endtask

    // Model: acceptance when the responder is free, access WS edges later
    initial begin
        for (int d = 0; d < 3; d++) begin
            last_acc[d] = -100;
            pend_v[d]   = 1'b0;
            pend_edge[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int d = 0; d < 3; d++) begin
                if (reset) begin
                    pend_v[d]   = 1'b0;
                    last_acc[d] = -100;
                    exp_q[d].delete();
                end else begin
                    if (req && cyc >= last_acc[d] + ws_of(d) + 2) begin
                        last_acc[d]  = cyc;
                        pend_v[d]    = 1'b1;
                        pend_edge[d] = cyc + ws_of(d);
                        p_we[d] = we; p_a[d] = a; p_wd[d] = wd; p_be[d] = be;
                    end
                    if (pend_v[d] && pend_edge[d] == cyc) begin
                        model_access(d);
                        pend_v[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares busy every cycle and pops the scoreboard on ready
    initial begin
        resp_t r;
        for (int d = 0; d < 3; d++) begin
            hold_rd[d]  = 32'h0;
            hold_err[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (reset) begin
                    hold_rd[d]  = 32'h0;
                    hold_err[d] = 1'b0;
                end
                check("busy", d, 32'(busy_s[d]),
                      32'((cyc >= last_acc[d]) && (cyc <= last_acc[d] + ws_of(d))));
                if (rdy_s[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_ready", d, 32'(rdy_s[d]), 32'h0);
                    end else begin
                        r = exp_q[d].pop_front();
                        check("ready_cycle", d, 32'(cyc), 32'(r.at_edge));
                        check("rd", d, rd_s[d], r.rd);
                        check("err", d, 32'(err_s[d]), 32'(r.err));
                        hold_rd[d]  = r.rd;
                        hold_err[d] = r.err;
                    end
                end else begin
                    if (exp_q[d].size() > 0 && exp_q[d][0].at_edge <= cyc) begin
                        r = exp_q[d].pop_front();
                        check("missing_ready", d, 32'(rdy_s[d]), 32'h1);
                    end
                    check("rd_hold", d, rd_s[d], hold_rd[d]);
                    check("err_hold", d, 32'(err_s[d]), 32'(hold_err[d]));
                end
            end
        end
    end

    // Asynchronous reset pulse with outputs checked before any clock edge
    task automatic reset_pulse();
        req = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", d, 32'(busy_s[d]), 32'h0);
            check("rst_ready", d, 32'(rdy_s[d]), 32'h0);
            check("rst_rd", d, rd_s[d], 32'h0);
            check("rst_err", d, 32'(err_s[d]), 32'h0);
        end
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // One request pulse, then scrambled inputs while all responders finish
    task automatic issue(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        req = 1'b1; we = w; a = ad; wd = d; be = m;
        @(negedge clk);
        req = 1'b0; we = 1'($urandom % 2); a = $urandom; wd = $urandom; be = 4'($urandom);
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] ad;
        ad = 32'(($urandom % 16) * 4);
        if ($urandom % 4 == 0) ad = ad + 32'($urandom % 4);
        case ($urandom % 6)
            4:       ad = ad + 32'h100;
            5:       ad = ad + 32'h8000_0000;
            default: ad = ad;
        endcase
        return ad;
    endfunction

    initial begin
        // Reset state before the first clock edge
        #1;
        for (int d = 0; d < 3; d++) begin
            check("init_busy", d, 32'(busy_s[d]), 32'h0);
            check("init_ready", d, 32'(rdy_s[d]), 32'h0);
            check("init_rd", d, rd_s[d], 32'h0);
            check("init_err", d, 32'(err_s[d]), 32'h0);
        end
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);

        // Full-word write/read, partial write, partial read
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'b1000);
        issue(1'b1, 32'h14, 32'h5555_AAAA, 4'h0);
        issue(1'b0, 32'h14, 32'h0, 4'hF);

        // req held through busy: only the free responders accept
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req = 1'b1; we = 1'b1; a = 32'h8; wd = $urandom; be = 4'hF;
        end
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        issue(1'b0, 32'h8, 32'h0, 4'hF);

        // Reset one wait cycle after accepting a write
        @(negedge clk);
        req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'hCAFE_F00D; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset_pulse();
        repeat (2) @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 4'hF);

        // Out-of-range and misaligned addresses
        issue(1'b1, 32'h102, 32'h0BAD_0BAD, 4'hF);
        issue(1'b1, 32'h100, 32'h1234_5678, 4'hF);
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        issue(1'b0, 32'h100, 32'h0, 4'hF);

        // Random traffic with occasional resets
        for (int n = 0; n < 900; n++) begin
            @(negedge clk);
            if (n % 150 == 149) begin
                reset_pulse();
            end else begin
                req = ($urandom % 3) != 0;
                we  = 1'($urandom % 2);
                a   = rand_addr();
                wd  = $urandom;
                be  = 4'($urandom);
            end
        end
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);

        for (int d = 0; d < 3; d++) check("drained", d, 32'(exp_q[d].size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
